// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiply sequencer.
//   state_t      : sequencer states
//   *_W_DEF      : default bus/dimension/element widths
package matmul_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DIM_W_DEF  = 16;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FETCH = 3'd2,
      WAIT  = 3'd3,
      MAC   = 3'd4,
      WRITE = 3'd5,
      DONE  = 3'd6
   } state_t;

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with writeback output stage.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the accumulator (takes priority over en)
//   en         : acc += op_a * op_b (full-precision signed product)
//   op_a, op_b : signed operands
//   wdata      : writeback value for C
// Build option MATMUL_SATURATE_EN: clamp acc to the signed DATA_W range on
// writeback; otherwise the low DATA_W bits are written (wrapping).
module matmul_mac import matmul_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = 2*DATA_W+8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] op_a,
   input  logic signed [DATA_W-1:0] op_b,
   output logic        [DATA_W-1:0] wdata
);

   localparam int PROD_W = 2*DATA_W;

   logic signed [ACC_W-1:0]  acc;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;

   assign prod     = op_a * op_b;
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod_ext;
      end
   end

`ifdef MATMUL_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   always_comb begin
      wdata = acc[DATA_W-1:0];
      if (acc > SAT_MAX) begin
         wdata = SAT_MAX[DATA_W-1:0];
      end else if (acc < SAT_MIN) begin
         wdata = SAT_MIN[DATA_W-1:0];
      end
   end
`else
   assign wdata = acc[DATA_W-1:0];
`endif

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for C[m][p] = A[m][n] x B[n][p], row-major, word addressed.
// Ports:
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   start_i                       : start pulse (ignored while busy_o)
//   a_base_i, b_base_i, c_base_i  : matrix base addresses
//   m_i, n_i, p_i                 : dimensions, sampled on accepted start
//   end_o, busy_o                 : completion pulse, job in progress
//   a_req/addr/gnt/rvalid/rdata   : A read bus (one outstanding access)
//   b_req/addr/gnt/rvalid/rdata   : B read bus (one outstanding access)
//   c_req/addr/wdata/gnt          : C write bus
// Build option MATMUL_SATURATE_EN selects saturating writeback (see matmul_mac).
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | job parameters latched; skip to DONE on any zero dimension
// FETCH | A and B requests raised for element k
// WAIT  | collecting A/B read data
// MAC   | acc += A[i][k]*B[k][j]; next k or writeback
// WRITE | C[i][j] write held until c_gnt_i; advance j, then i
// DONE  | end_o pulse, then back to IDLE
module matmul_ctrl import matmul_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = DIM_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = 2*DATA_W+8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] a_base_i,
   input  logic [ADDR_W-1:0] b_base_i,
   input  logic [ADDR_W-1:0] c_base_i,
   input  logic [DIM_W-1:0]  m_i,
   input  logic [DIM_W-1:0]  n_i,
   input  logic [DIM_W-1:0]  p_i,
   output logic              end_o,
   output logic              busy_o,
   output logic              a_req_o,
   output logic [ADDR_W-1:0] a_addr_o,
   input  logic              a_gnt_i,
   input  logic              a_rvalid_i,
   input  logic [DATA_W-1:0] a_rdata_i,
   output logic              b_req_o,
   output logic [ADDR_W-1:0] b_addr_o,
   input  logic              b_gnt_i,
   input  logic              b_rvalid_i,
   input  logic [DATA_W-1:0] b_rdata_i,
   output logic              c_req_o,
   output logic [ADDR_W-1:0] c_addr_o,
   output logic [DATA_W-1:0] c_wdata_o,
   input  logic              c_gnt_i
);

   state_t              state;
   logic [DIM_W-1:0]    m_r, n_r, p_r;
   logic [DIM_W-1:0]    i_cnt, j_cnt, k_cnt;
   logic [ADDR_W-1:0]   b_base_r;
   // a_row = a_base + i*n, b_col = b_base + j; the live pointers step from these.
   logic [ADDR_W-1:0]   a_row, a_ptr, b_col, b_ptr, c_ptr;
   logic                a_have, b_have;
   logic [DATA_W-1:0]   a_data, b_data;

   logic                last_k, last_j, last_i;
   logic [ADDR_W-1:0]   n_step, p_step;
   logic                mac_clr, mac_en;

   assign last_k = (k_cnt == n_r - DIM_W'(1));
   assign last_j = (j_cnt == p_r - DIM_W'(1));
   assign last_i = (i_cnt == m_r - DIM_W'(1));
   assign n_step = ADDR_W'(n_r);
   assign p_step = ADDR_W'(p_r);

   assign a_addr_o = a_ptr;
   assign b_addr_o = b_ptr;
   assign c_addr_o = c_ptr;

   assign mac_en  = (state == MAC);
   assign mac_clr = (state == LOAD) || ((state == WRITE) && c_gnt_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         m_r      <= '0;
         n_r      <= '0;
         p_r      <= '0;
         i_cnt    <= '0;
         j_cnt    <= '0;
         k_cnt    <= '0;
         b_base_r <= '0;
         a_row    <= '0;
         a_ptr    <= '0;
         b_col    <= '0;
         b_ptr    <= '0;
         c_ptr    <= '0;
         a_have   <= 1'b0;
         b_have   <= 1'b0;
         a_data   <= '0;
         b_data   <= '0;
         a_req_o  <= 1'b0;
         b_req_o  <= 1'b0;
         c_req_o  <= 1'b0;
         end_o    <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         // Handshakes on A/B run through FETCH and WAIT alike: gnt and rvalid
         // may land in the request cycle itself.
         if (state == FETCH || state == WAIT) begin
            if (a_req_o && a_gnt_i) a_req_o <= 1'b0;
            if (b_req_o && b_gnt_i) b_req_o <= 1'b0;
            if (!a_have && a_rvalid_i) begin
               a_have <= 1'b1;
               a_data <= a_rdata_i;
            end
            if (!b_have && b_rvalid_i) begin
               b_have <= 1'b1;
               b_data <= b_rdata_i;
            end
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  m_r      <= m_i;
                  n_r      <= n_i;
                  p_r      <= p_i;
                  b_base_r <= b_base_i;
                  a_row    <= a_base_i;
                  a_ptr    <= a_base_i;
                  b_col    <= b_base_i;
                  b_ptr    <= b_base_i;
                  c_ptr    <= c_base_i;
                  i_cnt    <= '0;
                  j_cnt    <= '0;
                  k_cnt    <= '0;
                  busy_o   <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (m_r == '0 || n_r == '0 || p_r == '0) begin
                  end_o <= 1'b1;
                  state <= DONE;
               end else begin
                  a_req_o <= 1'b1;
                  b_req_o <= 1'b1;
                  a_have  <= 1'b0;
                  b_have  <= 1'b0;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               state <= WAIT;
            end
            WAIT: begin
               if ((a_have || a_rvalid_i) && (b_have || b_rvalid_i)) begin
                  state <= MAC;
               end
            end
            MAC: begin
               if (!last_k) begin
                  k_cnt   <= k_cnt + DIM_W'(1);
                  a_ptr   <= a_ptr + ADDR_W'(1);
                  b_ptr   <= b_ptr + p_step;
                  a_req_o <= 1'b1;
                  b_req_o <= 1'b1;
                  a_have  <= 1'b0;
                  b_have  <= 1'b0;
                  state   <= FETCH;
               end else begin
                  c_req_o <= 1'b1;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               if (c_gnt_i) begin
                  c_req_o <= 1'b0;
                  c_ptr   <= c_ptr + ADDR_W'(1);
                  k_cnt   <= '0;
                  a_have  <= 1'b0;
                  b_have  <= 1'b0;
                  if (!last_j) begin
                     j_cnt   <= j_cnt + DIM_W'(1);
                     a_ptr   <= a_row;
                     b_col   <= b_col + ADDR_W'(1);
                     b_ptr   <= b_col + ADDR_W'(1);
                     a_req_o <= 1'b1;
                     b_req_o <= 1'b1;
                     state   <= FETCH;
                  end else if (!last_i) begin
                     j_cnt   <= '0;
                     i_cnt   <= i_cnt + DIM_W'(1);
                     a_row   <= a_row + n_step;
                     a_ptr   <= a_row + n_step;
                     b_col   <= b_base_r;
                     b_ptr   <= b_base_r;
                     a_req_o <= 1'b1;
                     b_req_o <= 1'b1;
                     state   <= FETCH;
                  end else begin
                     end_o <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               end_o  <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   matmul_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (mac_clr),
      .en    (mac_en),
      .op_a  (a_data),
      .op_b  (b_data),
      .wdata (c_wdata_o)
   );

endmodule
